// File: rtl/spi_flash_burst_reader.sv
// SPI NOR flash burst reader: single (0x0B), dual I/O (0xBB) or quad I/O (0xEB) reads of len bytes,
// streamed over valid/ready with the flash clock gated off while the consumer applies back-pressure.
module spi_flash_burst_reader #(
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 9,
  parameter int DUMMY_S = 8,
  parameter int DUMMY_Q = 4,
  parameter int CS_IDLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              cs,
  output logic              sck_en,
  output logic [3:0]        io_o,
  output logic [3:0]        io_oe,
  input  logic [3:0]        io_i
);

  localparam int PH_A   = (ADDR_W > DUMMY_S) ? ADDR_W : DUMMY_S;
  localparam int PH_B   = (PH_A > DUMMY_Q) ? PH_A : DUMMY_Q;
  localparam int PH_MAX = (PH_B > 8) ? PH_B : 8;
  localparam int CNT_W  = $clog2(PH_MAX);
  localparam int END_W  = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  localparam logic [1:0] M_SINGLE = 2'd0;
  localparam logic [1:0] M_DUAL   = 2'd1;
  localparam logic [1:0] M_QUAD   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_STALL, S_END
  } state_t;

  state_t            state;
  logic [1:0]        mode_r;
  logic [7:0]        cmd_sh;
  logic [ADDR_W-1:0] addr_sh;
  logic [LEN_W-1:0]  bytes_left;
  logic [CNT_W-1:0]  cnt;
  logic [6:0]        rx;
  logic [END_W-1:0]  end_cnt;

  logic [7:0]        cmd_byte;
  logic [3:0]        addr_io;
  logic [ADDR_W-1:0] addr_next;
  logic [3:0]        wide_oe;
  logic [CNT_W-1:0]  addr_last;
  logic [CNT_W-1:0]  mode_last;
  logic [CNT_W-1:0]  dummy_last;
  logic [CNT_W-1:0]  data_last;
  logic [7:0]        rx_next;
  logic              has_dummy;

  always_comb begin
    case (mode)
      M_DUAL:  cmd_byte = 8'hBB;
      M_QUAD:  cmd_byte = 8'hEB;
      default: cmd_byte = 8'h0B;
    endcase
  end

  // Per-mode lane width: what goes on the pins, phase lengths and how received bits are packed
  always_comb begin
    addr_io    = {3'b111, addr_sh[ADDR_W-1]};
    addr_next  = addr_sh << 1;
    wide_oe    = 4'b0001;
    addr_last  = CNT_W'(ADDR_W - 1);
    mode_last  = '0;
    dummy_last = CNT_W'(DUMMY_S - 1);
    has_dummy  = (DUMMY_S > 0);
    data_last  = CNT_W'(7);
    rx_next    = {rx[6:0], io_i[1]};
    case (mode_r)
      M_DUAL: begin
        addr_io   = {2'b11, addr_sh[ADDR_W-1 -: 2]};
        addr_next = addr_sh << 2;
        wide_oe   = 4'b0011;
        addr_last = CNT_W'(ADDR_W / 2 - 1);
        mode_last = CNT_W'(3);
        has_dummy = 1'b0;
        data_last = CNT_W'(3);
        rx_next   = {rx[5:0], io_i[1:0]};
      end
      M_QUAD: begin
        addr_io    = addr_sh[ADDR_W-1 -: 4];
        addr_next  = addr_sh << 4;
        wide_oe    = 4'b1111;
        addr_last  = CNT_W'(ADDR_W / 4 - 1);
        mode_last  = CNT_W'(1);
        dummy_last = CNT_W'(DUMMY_Q - 1);
        has_dummy  = (DUMMY_Q > 0);
        data_last  = CNT_W'(1);
        rx_next    = {rx[3:0], io_i};
      end
      default: ;
    endcase
  end

  // All pin and stream outputs are registered; each state decides what the next flash clock carries
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cs         <= 1'b1;
      sck_en     <= 1'b0;
      io_oe      <= 4'b0000;
      io_o       <= 4'hF;
      busy       <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      mode_r     <= M_SINGLE;
      cmd_sh     <= 8'h00;
      addr_sh    <= '0;
      bytes_left <= '0;
      cnt        <= '0;
      rx         <= '0;
      end_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            busy       <= 1'b1;
            mode_r     <= (mode == 2'd3) ? M_SINGLE : mode;
            addr_sh    <= addr;
            bytes_left <= len;
            cnt        <= '0;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state  <= S_CMD;
              cs     <= 1'b0;
              sck_en <= 1'b1;
              io_oe  <= 4'b0001;
              io_o   <= {3'b111, cmd_byte[7]};
              cmd_sh <= {cmd_byte[6:0], 1'b0};
            end
          end
        end
        S_CMD: begin
          if (cnt == CNT_W'(7)) begin
            state   <= S_ADDR;
            cnt     <= '0;
            io_oe   <= wide_oe;
            io_o    <= addr_io;
            addr_sh <= addr_next;
          end else begin
            cnt    <= cnt + 1'b1;
            io_o   <= {3'b111, cmd_sh[7]};
            cmd_sh <= {cmd_sh[6:0], 1'b0};
          end
        end
        S_ADDR: begin
          cnt     <= cnt + 1'b1;
          io_o    <= addr_io;
          addr_sh <= addr_next;
          if (cnt == addr_last) begin
            cnt  <= '0;
            io_o <= 4'hF;
            if (mode_r != M_SINGLE) begin
              state <= S_MODE;
            end else begin
              io_oe <= 4'b0000;
              state <= has_dummy ? S_DUMMY : S_DATA;
            end
          end
        end
        S_MODE: begin
          cnt <= cnt + 1'b1;
          if (cnt == mode_last) begin
            cnt   <= '0;
            io_oe <= 4'b0000;
            state <= has_dummy ? S_DUMMY : S_DATA;
          end
        end
        S_DUMMY: begin
          cnt <= cnt + 1'b1;
          if (cnt == dummy_last) begin
            cnt   <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          rx  <= rx_next[6:0];
          cnt <= cnt + 1'b1;
          if (cnt == data_last) begin
            cnt        <= '0;
            out_data   <= rx_next;
            out_valid  <= 1'b1;
            bytes_left <= bytes_left - 1'b1;
            if (bytes_left == LEN_W'(1)) begin
              state   <= S_END;
              cs      <= 1'b1;
              sck_en  <= 1'b0;
              end_cnt <= '0;
            end
          end else if (cnt == data_last - 1'b1 && out_valid && !out_ready) begin
            // Freeze just before the final clock of a byte so the pending byte is never overwritten
            state  <= S_STALL;
            sck_en <= 1'b0;
          end
        end
        S_STALL: begin
          if (out_ready) begin
            state  <= S_DATA;
            sck_en <= 1'b1;
          end
        end
        S_END: begin
          if (end_cnt == END_W'(CS_IDLE - 1) && (!out_valid || out_ready)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (end_cnt != END_W'(CS_IDLE - 1)) begin
            end_cnt <= end_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// Directed bench for spi_flash_burst_reader: a cycle-level flash model feeds io_i and records
// what the reader drives; results are compared against hand-computed values.
module tb_spi_flash_burst_reader;
  localparam int ADDR_W = 24;
  localparam int LEN_W  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              done;
  logic              cs;
  logic              sck_en;
  logic [3:0]        io_o;
  logic [3:0]        io_oe;
  logic [3:0]        io_i;

  spi_flash_burst_reader #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DUMMY_S(8), .DUMMY_Q(4), .CS_IDLE(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .addr(addr), .len(len),
    .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .cs(cs), .sck_en(sck_en), .io_o(io_o), .io_oe(io_oe), .io_i(io_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Flash model state
  logic [7:0]        mem [0:7];
  int                step = 1, aw = 24, mw = 0, hdr = 40, cpb = 8;
  int                fclk = 0;
  logic [3:0]        oe_log [0:63];
  logic [7:0]        cmd_rx = 8'h00;
  logic [ADDR_W-1:0] addr_rx = '0;
  logic [7:0]        mode_rx = 8'h00;
  int                cs_low = 0;
  int                done_cnt = 0;
  logic [7:0]        rx_q [$];

  always @(posedge clk) begin
    if (!cs) cs_low++;
    if (done) done_cnt++;
    if (out_valid && out_ready) rx_q.push_back(out_data);
    if (cs) begin
      fclk <= 0;
    end else if (sck_en) begin
      fclk <= fclk + 1;
      if (fclk < 64) oe_log[fclk] <= io_oe;
      if (fclk < 8) begin
        cmd_rx <= {cmd_rx[6:0], io_o[0]};
      end else if (fclk < 8 + aw) begin
        case (step)
          1:       addr_rx <= {addr_rx[ADDR_W-2:0], io_o[0]};
          2:       addr_rx <= {addr_rx[ADDR_W-3:0], io_o[1:0]};
          default: addr_rx <= {addr_rx[ADDR_W-5:0], io_o};
        endcase
      end else if (fclk < 8 + aw + mw) begin
        case (step)
          2:       mode_rx <= {mode_rx[5:0], io_o[1:0]};
          default: mode_rx <= {mode_rx[3:0], io_o};
        endcase
      end
    end
  end

  int         di, bi, ci;
  logic [7:0] bsh;
  always_comb begin
    io_i = 4'h0;
    di = 0; bi = 0; ci = 0;
    bsh = 8'h00;
    if (!cs && fclk >= hdr) begin
      di = fclk - hdr;
      bi = di / cpb;
      ci = di % cpb;
      if (bi < 8) bsh = mem[bi] << (ci * step);
      case (step)
        1:       io_i[1] = bsh[7];
        2:       io_i[1:0] = bsh[7:6];
        default: io_i = bsh[7:4];
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                               input logic [LEN_W-1:0] l, input logic [31:0] d);
    for (int i = 0; i < 4; i++) mem[i] = d[31-8*i -: 8];
    step = (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
    aw   = ADDR_W / step;
    mw   = (step == 1) ? 0 : 8 / step;
    hdr  = 8 + aw + mw + ((step == 1) ? 8 : (step == 4) ? 4 : 0);
    cpb  = 8 / step;
    cs_low = 0;
    done_cnt = 0;
    rx_q.delete();
    mode = m; addr = a; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int guard = 0;
    while (done_cnt == 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic checkStream(input string tag, input int n);
    checkOutput({tag, "_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(mem[i]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; mode = 2'd0; addr = '0; len = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs", 32'(cs), 32'd1);
    checkOutput("rst_sck_en", 32'(sck_en), 32'd0);
    checkOutput("rst_io_oe", 32'(io_oe), 32'h0);
    checkOutput("rst_io_o", 32'(io_o), 32'hF);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single read");
    applyStimulus(2'd0, 24'h400000, 9'd4, 32'h11223344);
    checkOutput("single_busy", 32'(busy), 32'd1);
    waitDone("single");
    checkOutput("single_cmd", 32'(cmd_rx), 32'h0B);
    checkOutput("single_addr", 32'(addr_rx), 32'h400000);
    checkOutput("single_oe_cmd", 32'(oe_log[0]), 32'h1);
    checkOutput("single_oe_addr", 32'(oe_log[31]), 32'h1);
    checkOutput("single_oe_dummy", 32'(oe_log[32]), 32'h0);
    checkOutput("single_oe_data", 32'(oe_log[40]), 32'h0);
    checkOutput("single_cs_low", 32'(cs_low), 32'd72);
    checkOutput("single_done_cnt", 32'(done_cnt), 32'd1);
    checkStream("single", 4);

    $display("[TB] dual read");
    applyStimulus(2'd1, 24'h400010, 9'd3, 32'hA55AC300);
    waitDone("dual");
    checkOutput("dual_cmd", 32'(cmd_rx), 32'hBB);
    checkOutput("dual_addr", 32'(addr_rx), 32'h400010);
    checkOutput("dual_mode_byte", 32'(mode_rx), 32'hFF);
    checkOutput("dual_oe_addr", 32'(oe_log[8]), 32'h3);
    checkOutput("dual_oe_mode", 32'(oe_log[23]), 32'h3);
    checkOutput("dual_oe_data", 32'(oe_log[24]), 32'h0);
    checkOutput("dual_cs_low", 32'(cs_low), 32'd36);
    checkStream("dual", 3);

    $display("[TB] quad read");
    applyStimulus(2'd2, 24'h000100, 9'd2, 32'hDEAD0000);
    waitDone("quad");
    checkOutput("quad_cmd", 32'(cmd_rx), 32'hEB);
    checkOutput("quad_addr", 32'(addr_rx), 32'h000100);
    checkOutput("quad_mode_byte", 32'(mode_rx), 32'hFF);
    for (int i = 8; i < 16; i++) checkOutput($sformatf("quad_oe_%0d", i), 32'(oe_log[i]), 32'hF);
    for (int i = 16; i < 20; i++) checkOutput($sformatf("quad_oe_%0d", i), 32'(oe_log[i]), 32'h0);
    checkOutput("quad_cs_low", 32'(cs_low), 32'd24);
    checkStream("quad", 2);

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    applyStimulus(2'd1, 24'h001000, 9'd4, 32'h01234567);
    guard = 0;
    while (!out_valid && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("bp_sck_en", 32'(sck_en), 32'd0);
    checkOutput("bp_cs", 32'(cs), 32'd0);
    checkOutput("bp_held_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_held_data", 32'(out_data), 32'h01);
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    waitDone("bp");
    checkStream("bp", 4);
    checkOutput("bp_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] zero length");
    applyStimulus(2'd0, 24'h000000, 9'd0, 32'h0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("zero_done_after", 32'(done), 32'd0);
    checkOutput("zero_busy_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("zero_cs_low", 32'(cs_low), 32'd0);
    checkOutput("zero_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] start while busy");
    applyStimulus(2'd0, 24'h012345, 9'd2, 32'h9C3E0000);
    repeat (20) @(negedge clk);
    mode = 2'd2; addr = 24'hFFFFFF; len = 9'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("busy_start");
    checkOutput("busy_start_cmd", 32'(cmd_rx), 32'h0B);
    checkOutput("busy_start_addr", 32'(addr_rx), 32'h012345);
    checkOutput("busy_start_cs_low", 32'(cs_low), 32'd56);
    checkOutput("busy_start_done_cnt", 32'(done_cnt), 32'd1);
    checkStream("busy_start", 2);

    $display("[TB] reset mid-burst");
    applyStimulus(2'd2, 24'h000100, 9'd2, 32'hDEAD0000);
    guard = 0;
    while (fclk < 20 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rst_mid_in_data", 32'(fclk >= 20), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_cs", 32'(cs), 32'd1);
    checkOutput("rst_mid_io_oe", 32'(io_oe), 32'h0);
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_mid_no_done", 32'(done_cnt), 32'd0);
    checkOutput("rst_mid_no_bytes", 32'(rx_q.size()), 32'd0);
    applyStimulus(2'd2, 24'h00ABC0, 9'd2, 32'h5C7E0000);
    waitDone("after_rst");
    checkOutput("after_rst_cmd", 32'(cmd_rx), 32'hEB);
    checkOutput("after_rst_addr", 32'(addr_rx), 32'h00ABC0);
    checkOutput("after_rst_cs_low", 32'(cs_low), 32'd24);
    checkStream("after_rst", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_burst_reader.md
Name: spi_flash_burst_reader

Overview:
Multi-mode SPI NOR flash burst reader, parametrised successor of the single-byte dual-I/O reader.
- One start reads `len` consecutive bytes in single (0x0B), dual I/O (0xBB) or quad I/O (0xEB) mode.
- Bytes are streamed out over a valid/ready interface; back-pressure is handled by gating the flash clock.
- Sits between the top-level control FSM (UART command handler) and the mspi pins. The top builds the inout pins from io_o/io_oe and drives the flash clock as clk gated by sck_en.

Parameters:
- ADDR_W, 24, flash address width in bits; must be a multiple of 4.
- LEN_W, 9, width of the len port; maximum burst is 2^LEN_W-1 bytes.
- DUMMY_S, 8, dummy clocks after the address in single mode.
- DUMMY_Q, 4, dummy clocks after the mode byte in quad mode.
- CS_IDLE, 2, minimum number of cycles cs stays high between bursts; must be ≥1.

Ports:
- clk  in  1  system clock; flash is clocked from the same clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request, accepted only when busy=0.
- mode  in  2  0=single 0x0B, 1=dual 0xBB, 2=quad 0xEB, 3=treated as single.
- addr  in  ADDR_W  start byte address, captured on accept.
- len  in  LEN_W  byte count, captured on accept; 0 = no-op.
- busy  out  1  high from accept until done.
- out_data  out  8  received byte.
- out_valid  out  1  out_data valid; held until out_ready.
- out_ready  in  1  consumer accepts out_data when valid&&ready.
- done  out  1  one-cycle pulse at end of burst.
- cs  out  1  flash chip select, active low.
- sck_en  out  1  flash clock enable; flash clock = clk gated.
- io_o  out  4  io[3:0] output values.
- io_oe  out  4  per-line output enable.
- io_i  in  4  io[3:0] sampled input.

Behaviour:
- Reset values: cs=1, sck_en=0, io_oe=0, io_o=4'hF, busy=0, out_valid=0, out_data=0, done=0. rst mid-burst aborts immediately to this state; no done pulse and no partial byte is emitted.
- All io activity is aligned to posedge clk. io_o changes on posedge; io_i is sampled on posedge while sck_en=1.
- Bit order is MSB first. Multi-line transfers put the higher bit on the higher io index: dual uses {io1,io0}, quad uses {io3..io0}.
- States: IDLE→CMD→ADDR→MODE→DUMMY→DATA(⇄STALL)→END→IDLE.
- IDLE: cs=1, sck_en=0. start seen in cycle T → the next cycle is the first CMD cycle: cs=0, sck_en=1, io_oe=4'b0001, io_o[0]=cmd[7].
- CMD: 8 cycles on io0 only; io_oe=0001.
- ADDR: single = ADDR_W cycles on io0 (oe=0001); dual = ADDR_W/2 cycles (oe=0011); quad = ADDR_W/4 cycles (oe=1111).
- MODE: dual = 4 cycles, quad = 2 cycles, driving mode byte 0xFF (no continuous-read mode). Skipped in single mode.
- DUMMY: single = DUMMY_S cycles, quad = DUMMY_Q cycles, dual = 0 cycles. io_oe=0 throughout.
- DATA: io_oe=0. Each byte takes 8/4/2 clocks (single/dual/quad). In single mode the data line is io1. The byte is assembled by shift.
- Byte complete at posedge P → out_data and out_valid=1 from P+1.
- If out_valid is still 1 when the next byte would complete, enter STALL: sck_en=0, cs stays 0, and the bit count is frozen. Resume from the next cycle after the handshake.
- The last byte never stalls the flash. cs rises as soon as it is sampled, and out_valid remains pending.
- END: cs=1, sck_en=0 for ≥CS_IDLE cycles, and wait until the last byte is handshaken. Then done=1 for one cycle, busy=0, return to IDLE. A new start is accepted in the cycle done is high.
- len=0: accept, no cs activity, done pulse 1 cycle after accept, busy high for that single cycle.
- start while busy: ignored. addr/len/mode changes during a burst have no effect.
- Address wrap-around is the flash's responsibility; the block sends only the start address.
- Cycle count with no stalls, cs low: single = 8+ADDR_W+DUMMY_S+8·len; dual = 8+ADDR_W/2+4+4·len; quad = 8+ADDR_W/4+2+DUMMY_Q+2·len.

Test Plan:
- Single, addr=0x400000, len=4, flash model preloaded 0x11 0x22 0x33 0x44, out_ready=1 → cmd 0x0B and address 0x400000 on io0. Stream is 11,22,33,44. cs low for exactly 72 cycles. One done pulse.
- Dual, addr=0x400010, len=3, data A5 5A C3 → cmd 0xBB on io0, address on io1:io0 over 12 cycles, 0xFF mode byte. Stream A5,5A,C3. cs low for 36 cycles.
- Quad, addr=0x000100, len=2, data DE AD → cmd 0xEB, 6 address cycles with oe=1111, mode cycles then 4 dummy cycles with oe=0000. Stream DE,AD. cs low 24 cycles.
- Back-pressure: dual, len=4, out_ready held low for 20 cycles after first valid → sck_en=0 and cs=0 while stalled. All 4 bytes delivered in order with none lost or duplicated.
- Edge cases: len=0 gives done one cycle after start with cs never low. A start pulsed mid-burst is ignored, and the burst completes unchanged.
- rst asserted during DATA of a quad burst → next cycle cs=1, io_oe=0, out_valid=0, busy=0, no done. A fresh burst afterwards reads correctly.
